boot_loader_p: RTL and testbench

- Parametrised successor of the serial boot loader: a byte-stream loader/dumper that owns the RAM port while `boot`=1.
- At reset it assembles LOAD_WORDS words of DATA_W bits from received bytes and writes them to RAM addresses 0..LOAD_WORDS-1, then releases the CPU (`boot`=0).
- On a `scan_memory` request it takes the RAM back and streams the same range out over tx.
- The UART byte engine is external; this block sees byte-level valid/ready streams. The top-level RAM mux selects this block's RAM signals when `boot`=1.

---
 rtl/boot_loader_p_pkg.sv | 26 ++
 rtl/boot_loader_p_shift_word.sv | 53 +++++
 rtl/boot_loader_p.sv | 191 +++++++++++++++++++
 tb/tb_boot_loader_p.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_p_pkg.sv
// Shared types and sizing helpers for the byte-stream boot loader.
// BOOT_CHECKSUM_EN adds the CHK state (trailing XOR checksum byte after a load).
package boot_pkg;

  typedef enum logic [2:0] {
    S_LOAD,
    S_WRITE,
    S_RUN,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_SEND
`ifdef BOOT_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  // BYTES_PER_WORD = DATA_W/8, CNT_W = $clog2(LOAD_WORDS+1); evaluated per instance.
  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int cnt_width(input int load_words);
    return $clog2(load_words + 1);
  endfunction

endpackage

// File: rtl/boot_loader_p_shift_word.sv
// boot_shift_word: DATA_W-bit MSB-first byte shift register with a byte down-counter.
// Used both to assemble rx words and to disassemble RAM words for tx.
module boot_shift_word
  import boot_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
  input  logic              shift,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic [7:0]        byte_out,
  output logic              last
);
  localparam int BPW  = bytes_per_word(DATA_W);
  localparam int BC_W = $clog2(BPW) + 1;

  logic [DATA_W-1:0] word_q, word_d;
  logic [BC_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W+7:0] shifted;

  // last is asserted while the byte being shifted completes the word
  assign last     = (cnt_q == '0);
  assign word     = word_q;
  assign byte_out = word_q[DATA_W-1 -: 8];

  always_comb begin
    shifted = {word_q, byte_in};
    word_d  = word_q;
    cnt_d   = cnt_q;
    if (load) begin
      word_d = load_word;
      cnt_d  = BC_W'(BPW - 1);
    end else if (shift) begin
      word_d = shifted[DATA_W-1:0];
      cnt_d  = last ? BC_W'(BPW - 1) : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      cnt_q  <= BC_W'(BPW - 1);
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/boot_loader_p.sv
// boot_loader_p: loads LOAD_WORDS words from an rx byte stream into RAM, then dumps them on request.
// Optional trailing checksum check enabled by BOOT_CHECKSUM_EN.
//
// state      | meaning
// S_LOAD     | assembling a word from rx bytes
// S_WRITE    | one-cycle RAM write of the assembled word
// S_RUN      | CPU owns RAM, waiting for a scan_memory rising edge
// S_RD_ISSUE | one-cycle RAM read
// S_RD_WAIT  | RAM data returns, latched into tx shifter
// S_SEND     | bytes out on tx, MSB first
// S_CHK      | waiting for the XOR checksum byte (BOOT_CHECKSUM_EN only)
module boot_loader_p
  import boot_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 6,
  parameter int LOAD_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              scan_memory,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] ram_out,
  output logic              boot,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_rw,
  output logic              ram_enable,
  output logic              load_err
);
  localparam int CNT_W = cnt_width(LOAD_WORDS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wc_q, wc_d;
  logic              scan_q;
  logic              scan_edge, wc_final;
  logic              rx_shift, tx_load, tx_shift;
  logic [DATA_W-1:0] rx_word, tx_word_unused;
  logic [7:0]        rx_byte_unused, tx_byte;
  logic              rx_last, tx_last;

  assign scan_edge = scan_memory & ~scan_q;
  assign wc_final  = (wc_q == CNT_W'(LOAD_WORDS - 1));
  assign boot      = (state_q != S_RUN);

  boot_shift_word #(.DATA_W(DATA_W)) u_rx (
    .clk(clk), .rst(rst), .load(1'b0), .load_word('0), .shift(ce & rx_shift),
    .byte_in(rx_data), .word(rx_word), .byte_out(rx_byte_unused), .last(rx_last)
  );

  boot_shift_word #(.DATA_W(DATA_W)) u_tx (
    .clk(clk), .rst(rst), .load(ce & tx_load), .load_word(ram_out), .shift(ce & tx_shift),
    .byte_in(8'h00), .word(tx_word_unused), .byte_out(tx_byte), .last(tx_last)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  logic       load_err_q, load_err_d, chk_fail;
  assign load_err = load_err_q;
`else
  assign load_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wc_d       = wc_q;
    rx_shift   = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    ram_enable = 1'b0;
    ram_rw     = 1'b0;
    ram_adr    = '0;
    ram_in     = '0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
`ifdef BOOT_CHECKSUM_EN
    chk_fail   = 1'b0;
`endif
    unique case (state_q)
      S_LOAD: begin
        if (rx_valid) begin
          rx_shift = 1'b1;
          if (rx_last) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ram_enable = 1'b1;
        ram_rw     = 1'b1;
        ram_adr    = ADDR_W'(wc_q);
        ram_in     = rx_word;
        if (wc_final) begin
          wc_d = '0;
`ifdef BOOT_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_RUN;
`endif
        end else begin
          wc_d    = wc_q + 1'b1;
          state_d = S_LOAD;
          // a byte landing here starts the next word; it may also complete it when DATA_W=8
          if (rx_valid) begin
            rx_shift = 1'b1;
            if (rx_last) state_d = S_WRITE;
          end
        end
      end
      S_RUN: begin
        if (scan_edge) state_d = S_RD_ISSUE;
      end
      S_RD_ISSUE: begin
        ram_enable = 1'b1;
        ram_adr    = ADDR_W'(wc_q);
        state_d    = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        tx_load = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = tx_byte;
        if (tx_ready) begin
          tx_shift = 1'b1;
          if (tx_last) begin
            if (wc_final) begin
              wc_d    = '0;
              state_d = S_RUN;
            end else begin
              wc_d    = wc_q + 1'b1;
              state_d = S_RD_ISSUE;
            end
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d = S_RUN;
          end else begin
            chk_fail = 1'b1;
            state_d  = S_LOAD;
          end
        end
      end
`endif
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOAD;
      wc_q    <= '0;
      scan_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      wc_q    <= wc_d;
      scan_q  <= scan_memory;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_comb begin
    chk_d      = chk_q;
    load_err_d = load_err_q;
    if (rx_shift) chk_d = chk_q ^ rx_data;
    if (chk_fail) begin
      chk_d      = 8'h00;
      load_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_q      <= 8'h00;
      load_err_q <= 1'b0;
    end else if (ce) begin
      chk_q      <= chk_d;
      load_err_q <= load_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_boot_loader_p.sv
// Self-checking bench for boot_loader_p at DATA_W=16, ADDR_W=2, LOAD_WORDS=4.
module tb_boot_loader_p;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int LOAD_WORDS = 4;

  logic              clk = 1'b0;
  logic              rst, ce, rx_valid, scan_memory, tx_ready;
  logic [7:0]        rx_data;
  logic [7:0]        tx_data;
  logic              tx_valid, boot, ram_rw, ram_enable, load_err;
  logic [DATA_W-1:0] ram_out, ram_in;
  logic [ADDR_W-1:0] ram_adr;

  typedef struct {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } wexp_t;

  typedef struct {
    logic [63:0] bytes;
    logic [63:0] words;
    logic [3:0]  rdy;
    int          exp_hi;
  } vec_t;

  wexp_t             wq[$];
  logic [7:0]        tq[$];
  logic [DATA_W-1:0] mem[LOAD_WORDS];
  logic [DATA_W-1:0] rd_q = '0;
  vec_t              tbl[3];

  int   checks = 0, failures = 0;
  int   cyc = 0, last_wr = 0, fall = 0, rd_count = 0, hi_count = 0;
  logic boot_prev = 1'b1, stalled = 1'b0;
  logic [7:0] held = 8'h00;

  boot_loader_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOAD_WORDS(LOAD_WORDS)) dut (
    .clk(clk), .rst(rst), .ce(ce), .rx_data(rx_data), .rx_valid(rx_valid),
    .scan_memory(scan_memory), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ram_out(ram_out), .boot(boot), .ram_adr(ram_adr), .ram_in(ram_in), .ram_rw(ram_rw),
    .ram_enable(ram_enable), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // synchronous RAM: read data valid the cycle after the read
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_rw) mem[ram_adr] <= ram_in;
      else rd_q <= mem[ram_adr];
    end
  end
  assign ram_out = rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic mon();
    wexp_t we;
    cyc++;
    if (ram_enable && ram_rw) begin
      last_wr = cyc;
      if (wq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        we = wq.pop_front();
        chk("wr_adr", 32'(ram_adr), 32'(we.adr));
        chk("wr_data", 32'(ram_in), 32'(we.data));
      end
    end
    if (ram_enable && !ram_rw) rd_count++;
    if (boot) hi_count++;
    if (boot_prev && !boot) fall = cyc;
    boot_prev = boot;
    if (tx_valid) begin
      if (stalled) chk("tx_hold", 32'(tx_data), 32'(held));
      if (tx_ready && ce) begin
        if (tq.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
        else chk("tx_byte", 32'(tx_data), 32'(tq.pop_front()));
      end
      stalled = !(tx_ready && ce);
      held = tx_data;
    end else begin
      stalled = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_boot", 32'(boot), 32'd1);
    chk("rst_ram_enable", 32'(ram_enable), 32'd0);
    chk("rst_ram_rw", 32'(ram_rw), 32'd0);
    chk("rst_ram_adr", 32'(ram_adr), 32'd0);
    chk("rst_ram_in", 32'(ram_in), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
  endtask

  task automatic reset_dut();
    rx_valid = 1'b0; rx_data = 8'h00; scan_memory = 1'b0; tx_ready = 1'b0; ce = 1'b1;
    rst = 1'b0;
    step();
    step();
    check_reset_outputs();
    rst = 1'b1;
    stalled = 1'b0;
    boot_prev = 1'b1;
  endtask

  task automatic load(input logic [63:0] bytes, input logic [63:0] words);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < LOAD_WORDS; k++) wq.push_back('{ADDR_W'(k), words[63-16*k -: 16]});
    fall = -100; last_wr = -1;
    for (int k = 0; k < 8; k++) begin
      rx_valid = 1'b1;
      rx_data = bytes[63-8*k -: 8];
      x = x ^ rx_data;
      step();
    end
    rx_valid = 1'b0; rx_data = 8'h00;
`ifdef BOOT_CHECKSUM_EN
    for (int i = 0; i < 10 && wq.size() != 0; i++) step();
    rx_valid = 1'b1; rx_data = x;
    step();
    rx_valid = 1'b0; rx_data = 8'h00;
    step();
`else
    for (int i = 0; i < 20 && boot; i++) step();
    step();
    chk("boot_fall_delay", 32'(fall - last_wr), 32'd1);
`endif
    chk("load_writes_left", 32'(wq.size()), 32'd0);
    chk("load_boot", 32'(boot), 32'd0);
  endtask

  task automatic dump(input logic [63:0] bytes, input logic [3:0] rdy, input int stall_at, input int exp_hi);
    logic done, saw_hi;
    logic [7:0] s_txd;
    logic s_txv, s_boot;
    for (int k = 0; k < 8; k++) tq.push_back(bytes[63-8*k -: 8]);
    rd_count = 0; hi_count = 0; done = 1'b0; saw_hi = 1'b0;
    scan_memory = 1'b1; tx_ready = rdy[3];
    step();
    scan_memory = 1'b0;
    for (int i = 1; i < 300 && !done; i++) begin
      if (i == stall_at) begin
        s_txd = tx_data; s_txv = tx_valid; s_boot = boot;
        ce = 1'b0; tx_ready = 1'b1;
        repeat (5) begin
          step();
          chk("ce_hold_tx_data", 32'(tx_data), 32'(s_txd));
          chk("ce_hold_tx_valid", 32'(tx_valid), 32'(s_txv));
          chk("ce_hold_boot", 32'(boot), 32'(s_boot));
        end
        ce = 1'b1;
      end
      tx_ready = rdy[3 - (i % 4)];
      step();
      if (boot) saw_hi = 1'b1;
      if (saw_hi && !boot && tq.size() == 0) done = 1'b1;
    end
    tx_ready = 1'b0;
    step();
    chk("dump_done", 32'(done), 32'd1);
    chk("dump_boot_rose", 32'(saw_hi), 32'd1);
    chk("dump_bytes_left", 32'(tq.size()), 32'd0);
    chk("dump_reads", 32'(rd_count), 32'(LOAD_WORDS));
    if (exp_hi >= 0) chk("dump_boot_cycles", 32'(hi_count), 32'(exp_hi));
    tq.delete();
  endtask

  initial begin
    tbl[0] = '{64'h123456789ABCDEF0, 64'h1234_5678_9ABC_DEF0, 4'b1111, 16};
    tbl[1] = '{64'h123456789ABCDEF0, 64'h1234_5678_9ABC_DEF0, 4'b1001, -1};
    tbl[2] = '{64'hA55A00FF0102FEDC, 64'hA55A_00FF_0102_FEDC, 4'b1010, -1};

    for (int r = 0; r < 3; r++) begin
      reset_dut();
      load(tbl[r].bytes, tbl[r].words);
      dump(tbl[r].bytes, tbl[r].rdy, -1, tbl[r].exp_hi);
    end

    // ce low for 5 cycles in the middle of SEND: 16 boot cycles become 21
    dump(tbl[2].bytes, 4'b1111, 4, 21);

    // reset after 3 of 8 bytes; the first word has already been written
    reset_dut();
    wq.push_back('{2'd0, 16'h1234});
    for (int k = 0; k < 3; k++) begin
      rx_valid = 1'b1;
      rx_data = tbl[0].bytes[63-8*k -: 8];
      step();
    end
    rst = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    step();
    check_reset_outputs();
    chk("midrst_writes_left", 32'(wq.size()), 32'd0);
    rst = 1'b1;
    boot_prev = 1'b1;
    load(tbl[0].bytes, tbl[0].words);

    // rx bytes in RUN must not touch RAM
    for (int k = 0; k < 2; k++) begin
      rx_valid = 1'b1; rx_data = 8'h55;
      step();
      chk("run_ignores_rx", 32'(ram_enable), 32'd0);
    end
    rx_valid = 1'b0;

`ifdef BOOT_CHECKSUM_EN
    begin
      logic [7:0] x;
      reset_dut();
      x = 8'h00;
      for (int k = 0; k < 8; k++) x = x ^ tbl[0].bytes[63-8*k -: 8];
      for (int k = 0; k < LOAD_WORDS; k++) wq.push_back('{ADDR_W'(k), tbl[0].words[63-16*k -: 16]});
      for (int k = 0; k < 8; k++) begin
        rx_valid = 1'b1; rx_data = tbl[0].bytes[63-8*k -: 8];
        step();
      end
      rx_valid = 1'b0;
      for (int i = 0; i < 10 && wq.size() != 0; i++) step();
      rx_valid = 1'b1; rx_data = x ^ 8'h08;
      step();
      rx_valid = 1'b0;
      step();
      chk("chk_bad_load_err", 32'(load_err), 32'd1);
      chk("chk_bad_boot", 32'(boot), 32'd1);
      load(tbl[0].bytes, tbl[0].words);
      chk("chk_good_load_err_sticky", 32'(load_err), 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
